// File: rtl/intr_timer_ctrl.sv
// Interrupt aggregator with a 64-bit free-running counter and compare flag.
// Optional FRC prescaler (adr 7) is built when FRC_PRESCALER_EN is defined.
module intr_timer_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [2:0]  reg_adr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic [3:0]  ext_irq,
  output logic        g_interrupt,
  output logic        g_interrupt_1shot,
  output logic        frc_cntr_val_leq
);

  localparam logic [2:0] A_FRC_LO = 3'd0;
  localparam logic [2:0] A_FRC_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO = 3'd2;
  localparam logic [2:0] A_CMP_HI = 3'd3;
  localparam logic [2:0] A_PEND   = 3'd4;
  localparam logic [2:0] A_EN     = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd6;
  localparam logic [2:0] A_PRESC  = 3'd7;

  logic [3:0]  sync1, sync2, sync3;
  logic [2:0]  arm;
  logic [3:0]  rise;
  logic [3:0]  pend, en;
  logic        ctrl;
  logic [63:0] frc, cmp;
  logic [31:0] shadow;
  logic [31:0] rd_mux;
  logic [3:0]  clr;
  logic        tick;
  logic        irq_any;
  logic [7:0]  presc_rd;

  logic we_frc_lo, we_frc_hi, we_cmp_lo, we_cmp_hi;
  logic we_pend, we_en, we_ctrl, we_presc;

  assign we_frc_lo = reg_we & (reg_adr == A_FRC_LO);
  assign we_frc_hi = reg_we & (reg_adr == A_FRC_HI);
  assign we_cmp_lo = reg_we & (reg_adr == A_CMP_LO);
  assign we_cmp_hi = reg_we & (reg_adr == A_CMP_HI);
  assign we_pend   = reg_we & (reg_adr == A_PEND);
  assign we_en     = reg_we & (reg_adr == A_EN);
  assign we_ctrl   = reg_we & (reg_adr == A_CTRL);
  assign we_presc  = reg_we & (reg_adr == A_PRESC);

  // arm masks edges until sync3 holds a real sample after reset,
  // so a line held high through reset release never reads as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      arm   <= '0;
    end else begin
      sync1 <= ext_irq;
      sync2 <= sync1;
      sync3 <= sync2;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  assign rise = sync2 & ~sync3 & {4{arm[2]}};
  assign clr  = we_pend ? reg_wdata[3:0] : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      en   <= '0;
      ctrl <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | rise;
      if (we_en)   en   <= reg_wdata[3:0];
      if (we_ctrl) ctrl <= reg_wdata[0];
    end
  end

`ifdef FRC_PRESCALER_EN
  logic [7:0] presc, pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (we_presc) presc <= reg_wdata[7:0];
      if (we_presc || !ctrl)  pcnt <= '0;
      else if (pcnt == presc) pcnt <= '0;
      else                    pcnt <= pcnt + 8'd1;
    end
  end

  assign tick     = ctrl & (pcnt == presc);
  assign presc_rd = presc;
`else
  logic unused_presc;

  assign unused_presc = we_presc;
  assign tick         = ctrl;
  assign presc_rd     = 8'h00;
`endif

  // a write to either half wins over the increment and leaves the other half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frc <= '0;
    end else if (we_frc_lo) begin
      frc[31:0] <= reg_wdata;
    end else if (we_frc_hi) begin
      frc[63:32] <= reg_wdata;
    end else if (tick) begin
      frc <= frc + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= '1;
    end else begin
      if (we_cmp_lo) cmp[31:0]  <= reg_wdata;
      if (we_cmp_hi) cmp[63:32] <= reg_wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_adr)
      A_FRC_LO: rd_mux = frc[31:0];
      A_FRC_HI: rd_mux = shadow;
      A_CMP_LO: rd_mux = cmp[31:0];
      A_CMP_HI: rd_mux = cmp[63:32];
      A_PEND:   rd_mux = {28'h0, pend};
      A_EN:     rd_mux = {28'h0, en};
      A_CTRL:   rd_mux = {31'h0, ctrl};
      A_PRESC:  rd_mux = {24'h0, presc_rd};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      reg_rdata <= '0;
    end else if (reg_re) begin
      reg_rdata <= rd_mux;
      if (reg_adr == A_FRC_LO) shadow <= frc[63:32];
    end
  end

  assign irq_any = |(pend & en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_interrupt       <= 1'b0;
      g_interrupt_1shot <= 1'b0;
      frc_cntr_val_leq  <= 1'b0;
    end else begin
      g_interrupt       <= irq_any;
      g_interrupt_1shot <= irq_any & ~g_interrupt;
      frc_cntr_val_leq  <= ctrl & (cmp <= frc);
    end
  end

endmodule

// File: doc/intr_timer_ctrl.md
INTR_TIMER_CTRL -- requirements
Module: intr_timer_ctrl

Interface
REQ-001 SHALL have these ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have these ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have these ports: reg_we  in  1  register write strobe, single cycle.
REQ-004 SHALL have these ports: reg_re  in  1  register read strobe, single cycle.
REQ-005 SHALL have these ports: reg_adr  in  3  word select: 0 FRC_LO, 1 FRC_HI, 2 CMP_LO, 3 CMP_HI, 4 IRQ_PEND, 5 IRQ_EN, 6 CTRL, 7 PRESC.
REQ-006 SHALL have these ports: reg_wdata  in  32  write data.
REQ-007 SHALL have these ports: reg_rdata  out  32  read data, registered, valid the cycle after reg_re.
REQ-008 SHALL have these ports: ext_irq  in  4  asynchronous external interrupt lines, active-high.
REQ-009 SHALL have these ports: g_interrupt  out  1  level: any enabled pending external interrupt.
REQ-010 SHALL have these ports: g_interrupt_1shot  out  1  one-cycle pulse on g_interrupt rising edge.
REQ-011 SHALL have these ports: frc_cntr_val_leq  out  1  level: timer enabled and CMP <= FRC.

Function
REQ-012 SHALL synchronise each ext_irq bit through two flops, then detect rising edges.
REQ-013 SHALL set IRQ_PEND[n] on a synchronised rising edge of ext_irq[n].
REQ-014 SHALL clear IRQ_PEND[n] on a write to adr 4 with reg_wdata[n]=1 (write-1-to-clear); bits [31:4] ignored.
REQ-015 SHALL give set priority over clear for the same bit in the same cycle.
REQ-016 SHALL register g_interrupt = |(IRQ_PEND & IRQ_EN[3:0]); latency edge-to-g_interrupt = 4 clk (2 sync, 1 edge/pend, 1 output reg).
REQ-017 SHALL assert g_interrupt_1shot for exactly one cycle when g_interrupt goes 0->1; no pulse while it stays high.
REQ-018 SHALL hold a 64-bit FRC that increments by 1 per tick while CTRL[0]=1 and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 SHALL load FRC_LO/FRC_HI on write; a write overrides the increment in that cycle, and the other half is not changed.
REQ-020 SHALL snapshot FRC[63:32] into a shadow register when FRC_LO is read; an FRC_HI read returns the shadow.
REQ-021 SHALL compute frc_cntr_val_leq as registered (CTRL[0] & CMP <= FRC), unsigned 64-bit, 1 cycle latency.
REQ-022 SHALL return 0 for unused bits and for reads of undefined fields; CTRL uses bit 0 only.
REQ-023 SHALL leave frc_cntr_val_leq asserted while the condition holds; software deasserts it by raising CMP or clearing CTRL[0].

Reset
REQ-024 SHALL on rst_n low clear FRC, shadow, IRQ_PEND, IRQ_EN, CTRL, PRESC, sync/edge flops and prescaler count; reg_rdata, g_interrupt, g_interrupt_1shot and frc_cntr_val_leq SHALL be 0.
REQ-025 SHALL reset CMP to 0xFFFF_FFFF_FFFF_FFFF so frc_cntr_val_leq cannot fire spuriously.
REQ-026 SHALL, if reset asserts mid-operation, drop all state immediately; an ext_irq held high through reset deassertion SHALL NOT set pending.

Configuration
REQ-027 SHALL, with FRC_PRESCALER_EN defined, implement an 8-bit PRESC (adr 7): a tick occurs once every PRESC+1 clk while CTRL[0]=1.
REQ-028 SHALL restart the prescale count at 0 on a PRESC write or on CTRL[0] clear.
REQ-029 SHALL, without FRC_PRESCALER_EN, tick every clk while CTRL[0]=1; adr 7 reads 0 and ignores writes.

Verification
REQ-030 SHALL cover: IRQ_EN=0x1, pulse ext_irq[0] -> g_interrupt high 4 clk later, 1shot one cycle; write IRQ_PEND=0x1 -> g_interrupt low next cycle.
REQ-031 SHALL cover: ext_irq[2] edge on the same cycle as a W1C of bit 2 -> IRQ_PEND[2] stays 1.
REQ-032 SHALL cover: CMP=0x10, CTRL=1, FRC=0 -> frc_cntr_val_leq rises when FRC reaches 0x10 (+1 clk); CMP=0x100 -> it deasserts.
REQ-033 SHALL cover: FRC=0xFFFF_FFFF_FFFF_FFFE, CTRL=1 -> after 2 ticks FRC=0; FRC_LO read then FRC_HI read returns the HI snapshot taken at the LO read.
REQ-034 SHALL cover: with FRC_PRESCALER_EN and PRESC=3 -> FRC advances 1 per 4 clk; without the macro -> 1 per clk, adr 7 reads 0.
REQ-035 SHALL cover: assert rst_n low while g_interrupt=1 and ext_irq=0xF held -> all outputs 0, no pending after release.
